// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - register bank with round-robin arbitrated write port
// One write per cycle from N_REQ requesters; combinational read port.
module reg_bank_arbiter #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int N_REQ  = 4,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*ADDR_W-1:0] addr_i,
  input  logic [N_REQ*WIDTH-1:0]  data_i,
  output logic [N_REQ-1:0]        gnt_o,
  input  logic [ADDR_W-1:0]       rd_addr_i,
  output logic [WIDTH-1:0]        rd_data_o,
  output logic                    wr_valid_o,
  output logic [ID_W-1:0]         wr_id_o,
  output logic                    err_o
);

  logic [WIDTH-1:0]  regs [DEPTH];
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0]  sel_data;
  logic              sel_in_range;
  logic              wr_en;
  int                scan;

  // Despite its name, rst_n is active-high; grants are suppressed while it is 1.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = 0;
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        scan = int'(ptr) + i;
        if (scan >= N_REQ) scan = scan - N_REQ;
        if (!gnt_any && req_i[ID_W'(scan)]) begin
          gnt_any = 1'b1;
          gnt_idx = ID_W'(scan);
        end
      end
    end
  end

  assign gnt_o        = gnt_any ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  assign sel_addr     = addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_data     = data_i[int'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_in_range = (int'(sel_addr) < DEPTH);
  assign wr_en        = gnt_any && sel_in_range;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      ptr        <= '0;
      wr_valid_o <= 1'b0;
      wr_id_o    <= '0;
      err_o      <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && (sel_addr == ADDR_W'(i))) regs[i] <= sel_data;
      end
      wr_valid_o <= gnt_any;
      if (gnt_any) begin
        wr_id_o <= gnt_idx;
        ptr     <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
        if (!sel_in_range) err_o <= 1'b1;
      end
    end
  end

  // Decoded read mux so out-of-range read addresses naturally return zero.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_i == ADDR_W'(i)) rd_data_o = regs[i];
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - directed scoreboard bench for reg_bank_arbiter
// DEPTH=6 so that out-of-range addresses are reachable.
module tb_reg_bank_arbiter;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 6;
  localparam int N_REQ  = 4;
  localparam int ADDR_W = 3;

  logic                    clk;
  logic                    rst_n;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*WIDTH-1:0]  data;
  logic [N_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]       rd_addr;
  logic [WIDTH-1:0]        rd_data;
  logic                    wr_valid;
  logic [1:0]              wr_id;
  logic                    err;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_item_t;

  sb_item_t sb[$];
  int checks = 0;
  int errors = 0;

  reg_bank_arbiter #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .N_REQ (N_REQ),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .addr_i    (addr),
    .data_i    (data),
    .gnt_o     (gnt),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .wr_valid_o(wr_valid),
    .wr_id_o   (wr_id),
    .err_o     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic exp(input string tag, input logic [31:0] val);
    sb_item_t it;
    it.tag = tag;
    it.val = val;
    sb.push_back(it);
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_item_t it;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%h expected=none", obs);
      return;
    end
    it = sb.pop_front();
    assert (obs === it.val)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.val);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int k, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    addr[k*ADDR_W +: ADDR_W] = a;
    data[k*WIDTH +: WIDTH]   = d;
  endtask

  task automatic rd(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] val);
    rd_addr = a;
    #1;
    exp(tag, val);
    chk(rd_data);
  endtask

  logic [3:0]  rr_seq [8];
  logic [31:0] final_regs [DEPTH];

  initial begin
    rr_seq = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    final_regs = '{32'h102, 32'hB, 32'h0, 32'hDEADBEEF, 32'h44, 32'h2};

    rst_n = 1'b1; req = 4'hF; addr = '0; data = '0; rd_addr = '0;
    #1;
    exp("gnt_rst0", 0); chk(gnt);
    cyc();
    exp("gnt_rst1", 0); chk(gnt);
    exp("wr_valid_rst", 0); chk(wr_valid);
    exp("wr_id_rst", 0); chk(wr_id);
    exp("err_rst", 0); chk(err);
    cyc();
    exp("gnt_rst2", 0); chk(gnt);
    rst_n = 1'b0;
    #1;
    exp("gnt_first", 4'b0001); chk(gnt);

    cyc();
    req = 4'h0;
    #1;
    exp("wr_valid_first", 1); chk(wr_valid);
    exp("wr_id_first", 0); chk(wr_id);
    exp("err_first", 0); chk(err);
    for (int a = 0; a < DEPTH; a++) rd($sformatf("rd_init%0d", a), ADDR_W'(a), 0);
    rd("rd_oor7", 3'd7, 0);

    // single write from requester 2
    cyc();
    req = 4'b0100; drv(2, 3'd3, 32'hDEADBEEF);
    #1;
    exp("gnt_single", 4'b0100); chk(gnt);
    cyc();
    req = 4'h0;
    rd("rd_single", 3'd3, 32'hDEADBEEF);
    exp("wr_valid_single", 1); chk(wr_valid);
    exp("wr_id_single", 2); chk(wr_id);
    cyc();
    #1;
    exp("wr_valid_idle", 0); chk(wr_valid);
    exp("wr_id_hold", 2); chk(wr_id);

    // round robin, pointer starts at 3
    for (int k = 0; k < N_REQ; k++) drv(k, 3'd0, 32'h100 + k);
    cyc();
    req = 4'hF;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp($sformatf("gnt_rr%0d", c), rr_seq[c]); chk(gnt);
      cyc();
    end

    // requester 3 write moves pointer back to 0
    req = 4'b1000; drv(3, 3'd4, 32'h44);
    #1;
    exp("gnt_r3", 4'b1000); chk(gnt);

    // same-address collision
    cyc();
    req = 4'b0011; drv(0, 3'd5, 32'h1); drv(1, 3'd5, 32'h2);
    #1;
    exp("gnt_col0", 4'b0001); chk(gnt);
    cyc();
    req = 4'b0010;
    rd("rd_col_first", 3'd5, 32'h1);
    exp("gnt_col1", 4'b0010); chk(gnt);
    exp("wr_id_col0", 0); chk(wr_id);
    cyc();
    req = 4'h0;
    rd("rd_col_last", 3'd5, 32'h2);
    exp("wr_id_col1", 1); chk(wr_id);
    rd("rd_rr_last", 3'd0, 32'h102);
    rd("rd_r3", 3'd4, 32'h44);

    // read during write
    cyc();
    req = 4'b0100; drv(2, 3'd1, 32'hA);
    #1;
    exp("gnt_rdw_pre", 4'b0100); chk(gnt);
    cyc();
    req = 4'b0001; drv(0, 3'd1, 32'hB);
    rd("rd_rdw_old", 3'd1, 32'hA);
    exp("gnt_rdw", 4'b0001); chk(gnt);
    cyc();
    req = 4'h0;
    rd("rd_rdw_new", 3'd1, 32'hB);

    // out-of-range write
    cyc();
    req = 4'b1000; drv(3, 3'd7, 32'hFFFF_FFFF);
    #1;
    exp("gnt_oor", 4'b1000); chk(gnt);
    exp("err_pre_oor", 0); chk(err);
    cyc();
    req = 4'h0;
    #1;
    exp("err_oor", 1); chk(err);
    exp("wr_valid_oor", 1); chk(wr_valid);
    exp("wr_id_oor", 3); chk(wr_id);
    for (int a = 0; a < DEPTH; a++) rd($sformatf("rd_final%0d", a), ADDR_W'(a), final_regs[a]);
    cyc();
    cyc();
    #1;
    exp("err_sticky", 1); chk(err);
    exp("wr_valid_idle2", 0); chk(wr_valid);

    // reset mid-operation with pending requests
    req = 4'hF; rst_n = 1'b1;
    #1;
    exp("gnt_rst_mid", 0); chk(gnt);
    cyc();
    exp("gnt_rst_mid2", 0); chk(gnt);
    exp("err_cleared", 0); chk(err);
    exp("wr_valid_rst_mid", 0); chk(wr_valid);
    rd("rd_cleared", 3'd3, 0);
    rst_n = 1'b0;
    #1;
    exp("gnt_after_rst", 4'b0001); chk(gnt);
    req = 4'h0;
    cyc();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
Bank of DEPTH storage registers, each WIDTH bits, shared by N_REQ independent writers.
A round-robin arbiter grants at most one write per cycle and drives the selected register's load enable.
Register semantics match the single-register primitive: hold when not loaded, load on a clock edge.
Sits between multiple producer engines and a shared configuration/status register space. Has one asynchronous-combinational read port.

Parameters:
WIDTH, 32, data width of each register
DEPTH, 8, number of registers in the bank (need not be a power of two)
N_REQ, 4, number of write requesters (>=2)
ADDR_W, $clog2(DEPTH) (min 1), register address width

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  synchronous reset, active-high: asserted when 1, sampled on posedge clk
req_i  input  N_REQ  per-requester write request; held until granted
addr_i  input  N_REQ*ADDR_W  per-requester target address; slice k = [k*ADDR_W +: ADDR_W]
data_i  input  N_REQ*WIDTH  per-requester write data; slice k = [k*WIDTH +: WIDTH]
gnt_o  output  N_REQ  one-hot (or zero) grant; the write commits on the posedge where it is high
rd_addr_i  input  ADDR_W  read address
rd_data_o  output  WIDTH  contents of register rd_addr_i
wr_valid_o  output  1  registered: a write committed on the previous edge
wr_id_o  output  $clog2(N_REQ)  registered: requester index of the last committed write
err_o  output  1  registered sticky flag: a granted write targeted addr >= DEPTH

Behaviour:
- Reset (rst_n=1 at posedge):
  - all registers 0, priority pointer 0, wr_valid_o 0, wr_id_o 0, err_o 0.
  - gnt_o is forced to 0 combinationally while rst_n=1; no write commits.
- Arbitration (combinational, same cycle):
  - Scan req_i starting at the priority pointer p, then p+1, ..., wrapping modulo N_REQ.
  - The first asserted requester k gets gnt_o[k]=1. All other grant bits are 0.
  - If req_i = 0, then gnt_o = 0.
- Pointer update: on a posedge with a grant to k, p <= (k+1) mod N_REQ. With no grant, p is unchanged.
- Write: on a posedge with gnt_o[k]=1 and addr_i slice k < DEPTH, register[addr k] <= data slice k. Exactly one register loads per cycle. Every other register holds.
- Out-of-range address (addr >= DEPTH, possible when DEPTH is not 2^n):
  - The requester is still granted (the handshake completes).
  - No register changes; err_o <= 1.
  - err_o stays 1 until reset.
- Handshake:
  - The requester must hold req/addr/data stable until it sees gnt_o[k]=1 at a posedge.
  - It may deassert or present a new request in the following cycle.
  - Back-to-back requests from the same requester are allowed. Fairness guarantees any waiting requester is granted within N_REQ cycles.
- Read port:
  - rd_data_o = register[rd_addr_i], combinational. Returns 0 when rd_addr_i >= DEPTH.
  - Read-during-write to the same address returns the OLD value in that cycle and the new value after the edge (one-cycle write-to-read latency).
- Status outputs:
  - wr_valid_o <= (grant this cycle).
  - wr_id_o <= k when granted, else it holds.
  - Out-of-range writes also set wr_valid_o.
- Simultaneous requests to the same address from different requesters: serialised over successive cycles in round-robin order. The last granted write wins.
- Reset mid-operation: pending requests are not granted during reset. After reset, arbitration restarts from pointer 0; requesters must keep their req asserted.

Test Plan:
- Reset: drive rst_n=1 for 2 cycles with req_i=4'b1111 -> gnt_o=0 throughout; after release, all rd_data_o=0, err_o=0, first grant goes to requester 0.
- Single write: req_i=4'b0100, addr2=3, data2=32'hDEADBEEF -> gnt_o=4'b0100 same cycle; next cycle rd_addr_i=3 reads 32'hDEADBEEF, wr_valid_o=1, wr_id_o=2.
- Round-robin: req_i=4'b1111 held for 8 cycles -> gnt_o sequence 0001,0010,0100,1000,0001,...; no requester starved.
- Same-address collision: req0 writes addr 5 = 32'h1 and req1 writes addr 5 = 32'h2, pointer 0 -> 32'h1 committed first, then 32'h2; final read of addr 5 = 32'h2.
- Read-during-write: register 1 holds 32'hA; write 32'hB to addr 1 while rd_addr_i=1 -> rd_data_o=32'hA that cycle, 32'hB the next.
- Out-of-range (DEPTH=6): req3 targets addr 7 -> gnt_o[3]=1, no register changes, err_o=1 the next cycle and sticky until reset.
